// File: rtl/kbd_matrix_port_pkg.sv
// Shared types and sizes for the keyboard/joystick matrix read port.
package kbd_pkg;

    localparam int KBD_ROWS     = 8;
    localparam int KBD_COLS     = 8;
    localparam int KBD_ROW_BITS = 3;

    typedef logic [KBD_COLS-1:0]               kbd_row_t;
    typedef logic [KBD_ROWS-1:0][KBD_COLS-1:0] kbd_matrix_t;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/kbd_matrix_port_if.sv
// CPU read bus: address + one-cycle read strobe out, row byte + valid back.
interface kbd_matrix_port_if;
    import kbd_pkg::*;

    logic [15:0] cpu_addr;
    logic        cpu_rd;
    kbd_row_t    cpu_dout;
    logic        cpu_dout_vld;

    modport master (output cpu_addr, output cpu_rd, input cpu_dout, input cpu_dout_vld);
    modport slave  (input cpu_addr, input cpu_rd, output cpu_dout, output cpu_dout_vld);

endinterface

// File: rtl/kbd_key_stretch.sv
// One matrix key: holds a press visible for HOLD_TICKS ticks after its falling edge.
// Output is registered, one cycle behind raw; no backpressure.
module kbd_key_stretch
    import kbd_pkg::*;
#(
    parameter int HOLD_TICKS = 20
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    input  logic bypass,
    output logic stretched
);

    localparam int            CW   = cnt_width(HOLD_TICKS);
    localparam logic [CW-1:0] HOLD = CW'(HOLD_TICKS);

    logic          prev;
    logic          press;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // A fresh press reloads even when a tick lands in the same cycle.
    always_comb begin
        press    = prev & ~raw;
        cnt_next = cnt;
        if (press) begin
            cnt_next = HOLD;
        end else if (tick && (cnt != '0)) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= 1'b1;
            cnt       <= '0;
            stretched <= 1'b1;
        end else begin
            prev <= raw;
            if (bypass) begin
                cnt       <= '0;
                stretched <= raw;
            end else begin
                cnt       <= cnt_next;
                stretched <= raw & (cnt_next == '0);
            end
        end
    end

endmodule

// File: rtl/kbd_matrix_port.sv
// CPU read port for the 8x8 active-low matrix: stretched rows, 1-cycle read latency, no backpressure.
// Optional key-press interrupt built only when KBD_IRQ_EN is defined; otherwise kbd_irq is tied low.
module kbd_matrix_port
    import kbd_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h3800,
    parameter int          TICK_DIV     = 50000,
    parameter int          HOLD_TICKS   = 20,
    parameter logic [7:0]  STRETCH_MASK = 8'h7F
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  kbd_matrix_t        keys_in,
    kbd_matrix_port_if.slave   cpu,
    output logic               key_any,
    output logic               kbd_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    kbd_matrix_t   stretched;
    logic          hit;

    // Shared hold-time prescaler; TICK_DIV of 1 ticks every cycle.
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar r = 0; r < KBD_ROWS; r++) begin : g_row
        for (genvar c = 0; c < KBD_COLS; c++) begin : g_col
            kbd_key_stretch #(
                .HOLD_TICKS (HOLD_TICKS)
            ) u_key (
                .clk_sys   (clk_sys),
                .rst_n     (rst_n),
                .raw       (keys_in[r][c]),
                .tick      (tick),
                .bypass    (~STRETCH_MASK[r]),
                .stretched (stretched[r][c])
            );
        end
    end

    assign hit = cpu.cpu_rd && (cpu.cpu_addr[15:KBD_ROW_BITS] == BASE_ADDR[15:KBD_ROW_BITS]);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cpu.cpu_dout     <= 8'hFF;
            cpu.cpu_dout_vld <= 1'b0;
            key_any          <= 1'b0;
        end else begin
            cpu.cpu_dout     <= hit ? stretched[cpu.cpu_addr[KBD_ROW_BITS-1:0]] : 8'hFF;
            cpu.cpu_dout_vld <= hit;
            key_any          <= (stretched != '1);
        end
    end

`ifdef KBD_IRQ_EN
    kbd_matrix_t stretched_d;
    logic        irq_q;

    // A new fall outranks a read hit in the same cycle so no press is lost.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stretched_d <= '1;
            irq_q       <= 1'b0;
        end else begin
            stretched_d <= stretched;
            if ((stretched_d & ~stretched) != '0) begin
                irq_q <= 1'b1;
            end else if (hit) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign kbd_irq = irq_q;
`else
    assign kbd_irq = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_matrix_port.sv
// Bench for kbd_matrix_port: reference model driven by tick arithmetic, vector table, directed sequences.
module tb_kbd_matrix_port;
    import kbd_pkg::*;

    localparam logic [15:0] BASE = 16'h3800;
    localparam int          TD   = 4;
    localparam int          HT   = 5;
    localparam logic [7:0]  MASK = 8'h7F;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    kbd_matrix_t keys_in = '1;
    logic        key_any;
    logic        kbd_irq;

    kbd_matrix_port_if bus ();

    kbd_matrix_port #(
        .BASE_ADDR    (BASE),
        .TICK_DIV     (TD),
        .HOLD_TICKS   (HT),
        .STRETCH_MASK (MASK)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .keys_in (keys_in),
        .cpu     (bus),
        .key_any (key_any),
        .kbd_irq (kbd_irq)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a key reads pressed while raw is low, or while fewer than HT
    // prescaler wraps have elapsed since its latest press edge.
    kbd_matrix_t m_prev, m_str, m_str_d;
    int          m_press [8][8];
    bit          m_pressed [8][8];
    int          m_cyc;
    logic [7:0]  m_dout;
    logic        m_vld, m_any, m_irq;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        vld;
        logic [7:0]  dout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '1;
        m_str   = '1;
        m_str_d = '1;
        m_cyc   = 0;
        m_dout  = 8'hFF;
        m_vld   = 1'b0;
        m_any   = 1'b0;
        m_irq   = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                m_pressed[r][c] = 1'b0;
                m_press[r][c]   = 0;
            end
    endtask

    task automatic model_update();
        logic        hit;
        logic        raw;
        int          tk;
        kbd_matrix_t nxt;
        hit    = bus.cpu_rd && (bus.cpu_addr[15:3] == BASE[15:3]);
        m_vld  = hit;
        m_dout = hit ? m_str[bus.cpu_addr[2:0]] : 8'hFF;
        m_any  = (m_str != '1);
`ifdef KBD_IRQ_EN
        m_irq  = ((m_str_d & ~m_str) != '0) || (m_irq && !hit);
`else
        m_irq  = 1'b0;
`endif
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                raw = keys_in[r][c];
                if (m_prev[r][c] && !raw) begin
                    m_pressed[r][c] = 1'b1;
                    m_press[r][c]   = m_cyc;
                end
                tk = (m_cyc + 1) / TD - (m_press[r][c] + 1) / TD;
                nxt[r][c] = raw && !(MASK[r] && (HT > 0) && m_pressed[r][c] && (tk < HT));
            end
        m_str_d = m_str;
        m_str   = nxt;
        m_prev  = keys_in;
        m_cyc++;
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_update();
        @(negedge clk_sys);
        chk("mdl_dout", 32'(bus.cpu_dout), 32'(m_dout));
        chk("mdl_vld", 32'(bus.cpu_dout_vld), 32'(m_vld));
        chk("mdl_any", 32'(key_any), 32'(m_any));
        chk("mdl_irq", 32'(kbd_irq), 32'(m_irq));
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    task automatic read_setup(input logic [15:0] a, input logic r);
        bus.cpu_addr = a;
        bus.cpu_rd   = r;
    endtask

    vec_t       vt [8];
    logic [7:0] hist [0:40];
    int         fe, bad_cnt;
    bit         irq_exp;

    initial begin
        bus.cpu_addr = 16'h0000;
        bus.cpu_rd   = 1'b0;
        model_reset();

        // 1: reset state
        do_reset();
        chk("rst_dout", 32'(bus.cpu_dout), 32'hFF);
        chk("rst_vld", 32'(bus.cpu_dout_vld), 32'h0);
        chk("rst_any", 32'(key_any), 32'h0);
        chk("rst_irq", 32'(kbd_irq), 32'h0);
        repeat (3) step();

        // 2: short tap stretched to HT ticks
        do_reset();
        read_setup(16'h3804, 1'b1);
        keys_in[4][0] = 1'b0;
        fe = 0;
        for (int i = 1; i <= 26; i++) begin
            step();
            if (i == 2) keys_in[4][0] = 1'b1;
            if (i == 1) chk("t2_pre", 32'(bus.cpu_dout), 32'hFF);
            if (i == 2) chk("t2_first", 32'(bus.cpu_dout), 32'hFE);
            if (bus.cpu_dout == 8'hFE) fe++;
        end
        chk("t2_len_ok", 32'((fe >= 4 * (HT - 1) + 1) && (fe <= 4 * HT)), 32'h1);
        chk("t2_end", 32'(bus.cpu_dout), 32'hFF);

        // 3: long hold, release after 100 cycles
        do_reset();
        read_setup(16'h3805, 1'b1);
        keys_in[5][3] = 1'b0;
        bad_cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (i >= 2 && bus.cpu_dout != 8'hF7) bad_cnt++;
        end
        chk("t3_hold", 32'(bad_cnt), 32'h0);
        keys_in[5][3] = 1'b1;
        step();
        chk("t3_rel1", 32'(bus.cpu_dout), 32'hF7);
        step();
        chk("t3_rel2", 32'(bus.cpu_dout), 32'hFF);

        // 4: joystick row passes through with one cycle of lag
        do_reset();
        read_setup(16'h3807, 1'b1);
        for (int i = 0; i <= 30; i++) begin
            if (i % 3 == 0) keys_in[7][2] = ~keys_in[7][2];
            hist[i] = keys_in[7];
            step();
            if (i >= 1) chk("t4_lag", 32'(bus.cpu_dout), 32'(hist[i-1]));
        end
        keys_in = '1;

        // 5: address decode table
        vt[0] = '{16'h3803, 1'b1, 1'b1, 8'hFD};
        vt[1] = '{16'h3808, 1'b1, 1'b0, 8'hFF};
        vt[2] = '{16'h37FF, 1'b1, 1'b0, 8'hFF};
        vt[3] = '{16'h3800, 1'b0, 1'b0, 8'hFF};
        vt[4] = '{16'h3803, 1'b1, 1'b1, 8'hFD};
        vt[5] = '{16'h3803, 1'b1, 1'b1, 8'hFD};
        vt[6] = '{16'hB803, 1'b1, 1'b0, 8'hFF};
        vt[7] = '{16'h3800, 1'b1, 1'b1, 8'hFF};
        do_reset();
        read_setup(16'h0000, 1'b0);
        keys_in[3][1] = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            read_setup(vt[i].addr, vt[i].rd);
            step();
            chk("t5_vld", 32'(bus.cpu_dout_vld), 32'(vt[i].vld));
            chk("t5_dout", 32'(bus.cpu_dout), 32'(vt[i].dout));
        end
        keys_in = '1;

        // 6: interrupt set, clear by read, set wins over a same-cycle read
`ifdef KBD_IRQ_EN
        irq_exp = 1'b1;
`else
        irq_exp = 1'b0;
`endif
        do_reset();
        read_setup(16'h0000, 1'b0);
        keys_in[0][0] = 1'b0;
        step();
        keys_in[0][0] = 1'b1;
        step();
        step();
        chk("t6_set", 32'(kbd_irq), 32'(irq_exp));
        read_setup(16'h3800, 1'b1);
        step();
        read_setup(16'h0000, 1'b0);
        chk("t6_clr", 32'(kbd_irq), 32'h0);
        keys_in[0][1] = 1'b0;
        step();
        read_setup(16'h3800, 1'b1);
        step();
        read_setup(16'h0000, 1'b0);
        chk("t6_race", 32'(kbd_irq), 32'(irq_exp));
        step();
        chk("t6_hold", 32'(kbd_irq), 32'(irq_exp));
        keys_in = '1;

        // 7: reset in the middle of a stretch
        do_reset();
        keys_in[1][1] = 1'b0;
        keys_in[6][7] = 1'b0;
        step();
        keys_in = '1;
        repeat (4) step();
        do_reset();
        for (int r = 0; r < 8; r++) begin
            read_setup(16'h3800 + 16'(r), 1'b1);
            step();
            chk("t7_row", 32'(bus.cpu_dout), 32'hFF);
            chk("t7_any", 32'(key_any), 32'h0);
            chk("t7_irq", 32'(kbd_irq), 32'h0);
        end

        // Random presses and reads against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0)
                keys_in[$urandom_range(0, 7)][$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0)
                read_setup(16'($urandom), $urandom_range(0, 1) == 1);
            else
                read_setup(16'h3800 + 16'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
